// File: rtl/irrigation_pkg.sv
// Shared types, default cycle constants and level helpers
// for the irrigation sequencer.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPRINKLE,
        DRIP,
        FAULT
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES     = 8;
    localparam int DEF_MIN_ON_CYCLES       = 1000;
    localparam int DEF_FILL_TIMEOUT_CYCLES = 50000;
    localparam int DEF_CNT_W               = 16;

    // A probe above can never be wet while a probe below is dry.
    function automatic logic level_inconsistent(
        input logic low,
        input logic mid,
        input logic high
    );
        return (mid & ~low) | (high & ~mid);
    endfunction

endpackage

// File: rtl/irrigation_sequencer_debounce.sv
// Two-flop synchroniser followed by a stability counter; the
// clean output follows the input after DEBOUNCE_CYCLES stable cycles.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// Tank fill control and sprinkler/drip sequencing with fault alarm.
// Optional ALARM_LATCH_EN: alarms latch until alarm_clr.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int MIN_ON_CYCLES       = DEF_MIN_ON_CYCLES,
    parameter int FILL_TIMEOUT_CYCLES = DEF_FILL_TIMEOUT_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic low,
    input  logic mid,
    input  logic high,
    input  logic Us,
    input  logic Ua,
    input  logic T,
    output logic watter_supply,
    output logic asp,
    output logic got,
    output logic error,
    output logic alarme
`ifdef ALARM_LATCH_EN
    ,
    input  logic alarm_clr
`endif
);

    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(FILL_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] RUN_MIN  = CNT_W'(MIN_ON_CYCLES);

    logic [5:0]       raw;
    logic [5:0]       filt;
    logic             low_f;
    logic             mid_f;
    logic             high_f;
    logic             us_f;
    logic             ua_f;
    logic             t_f;
    logic             lvl_bad;
    logic             clr_ok;
    logic             timeout_flag;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] run_cnt;
    state_t           state;
    state_t           state_nx;

    assign raw = {T, Ua, Us, high, mid, low};

    for (genvar i = 0; i < 6; i++) begin : g_db
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .clean(filt[i])
        );
    end

    assign low_f  = filt[0];
    assign mid_f  = filt[1];
    assign high_f = filt[2];
    assign us_f   = filt[3];
    assign ua_f   = filt[4];
    assign t_f    = filt[5];

`ifdef ALARM_LATCH_EN
    assign clr_ok = alarm_clr & ~error;
`else
    assign clr_ok = 1'b0;
`endif

    // Unregistered term keeps the valve from blipping open before error lands.
    assign lvl_bad = level_inconsistent(low_f, mid_f, high_f) | error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error         <= 1'b0;
            watter_supply <= 1'b0;
            fill_cnt      <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            error <= level_inconsistent(low_f, mid_f, high_f);
            if (high_f | lvl_bad | timeout_flag | (state == FAULT)) begin
                watter_supply <= 1'b0;
            end else if (!mid_f) begin
                watter_supply <= 1'b1;
            end
            if (!watter_supply) begin
                fill_cnt <= '0;
            end else if (fill_cnt != '1) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (watter_supply && fill_cnt >= FILL_MAX) begin
                timeout_flag <= 1'b1;
            end else if (clr_ok) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (error) begin
                    state_nx = FAULT;
                end else if (us_f && low_f) begin
                    state_nx = (t_f | ua_f) ? DRIP : SPRINKLE;
                end
            end
            SPRINKLE, DRIP: begin
                if (error) begin
                    state_nx = FAULT;
                end else if (!low_f) begin
                    state_nx = IDLE;
                end else if (!us_f && run_cnt >= RUN_MIN) begin
                    state_nx = IDLE;
                end
            end
            FAULT: begin
`ifdef ALARM_LATCH_EN
                if (!error && alarm_clr) state_nx = IDLE;
`else
                if (!error) state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
            asp     <= 1'b0;
            got     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state != SPRINKLE && state != DRIP) begin
                run_cnt <= '0;
            end else if (run_cnt != '1) begin
                run_cnt <= run_cnt + 1'b1;
            end
            asp <= (state == SPRINKLE);
            got <= (state == DRIP);
        end
    end

    assign alarme = (state == FAULT) | timeout_flag;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with short cycle parameters;
// covers ALARM_LATCH_EN when that macro is defined.
module tb_irrigation_sequencer;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic low  = 1'b1;
    logic mid  = 1'b1;
    logic high = 1'b1;
    logic us   = 1'b0;
    logic ua   = 1'b0;
    logic t    = 1'b0;
    logic watter_supply;
    logic asp;
    logic got;
    logic error;
    logic alarme;
`ifdef ALARM_LATCH_EN
    logic alarm_clr = 1'b0;
`endif

    int checks = 0;
    int passes = 0;
    logic found;

    always #5 clk = ~clk;

    irrigation_sequencer #(
        .DEBOUNCE_CYCLES    (2),
        .MIN_ON_CYCLES      (10),
        .FILL_TIMEOUT_CYCLES(20),
        .CNT_W              (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .low          (low),
        .mid          (mid),
        .high         (high),
        .Us           (us),
        .Ua           (ua),
        .T            (t),
        .watter_supply(watter_supply),
        .asp          (asp),
        .got          (got),
        .error        (error),
        .alarme       (alarme)
`ifdef ALARM_LATCH_EN
        ,
        .alarm_clr    (alarm_clr)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    initial begin
        // Reset with a full, consistent tank.
        tick(3);
        check("rst_supply", watter_supply, 1'b0);
        check("rst_asp", asp, 1'b0);
        check("rst_got", got, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_alarme", alarme, 1'b0);
        rst = 1'b0;
        tick(10);
        check("idle_supply", watter_supply, 1'b0);
        check("idle_error", error, 1'b0);
        check("idle_alarme", alarme, 1'b0);

        // Level falls below mid: valve opens 5 cycles later.
        mid = 1'b0;
        high = 1'b0;
        tick(4);
        check("fill_open_early", watter_supply, 1'b0);
        tick(1);
        check("fill_open", watter_supply, 1'b1);
        mid = 1'b1;
        high = 1'b1;
        tick(4);
        check("fill_close_early", watter_supply, 1'b1);
        tick(1);
        check("fill_close", watter_supply, 1'b0);
        check("fill_error", error, 1'b0);
        tick(5);

        // Sprinkler run held to the minimum on-time.
        us = 1'b1;
        tick(5);
        check("spr_asp_early", asp, 1'b0);
        tick(1);
        check("spr_asp_on", asp, 1'b1);
        check("spr_got_off", got, 1'b0);
        tick(2);
        us = 1'b0;
        tick(8);
        check("spr_min_hold", asp, 1'b1);
        tick(1);
        check("spr_asp_off", asp, 1'b0);
        tick(3);

        // Drip run cut short by loss of the low level.
        us = 1'b1;
        t = 1'b1;
        tick(5);
        check("drip_got_early", got, 1'b0);
        tick(1);
        check("drip_got_on", got, 1'b1);
        check("drip_asp_off", asp, 1'b0);
        low = 1'b0;
        mid = 1'b0;
        high = 1'b0;
        us = 1'b0;
        t = 1'b0;
        tick(5);
        check("drip_dry_hold", got, 1'b1);
        tick(1);
        check("drip_dry_off", got, 1'b0);
        low = 1'b1;
        mid = 1'b1;
        high = 1'b1;
        tick(10);

        // High wet with mid dry: inconsistent levels.
        mid = 1'b0;
        tick(5);
        check("flt_error", error, 1'b1);
        tick(1);
        check("flt_alarme", alarme, 1'b1);
        check("flt_asp", asp, 1'b0);
        check("flt_got", got, 1'b0);
        check("flt_supply", watter_supply, 1'b0);
        mid = 1'b1;
        tick(5);
        check("flt_error_clr", error, 1'b0);
        tick(1);
`ifdef ALARM_LATCH_EN
        check("flt_alarm_latched", alarme, 1'b1);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        check("flt_alarm_cleared", alarme, 1'b0);
`else
        check("flt_alarm_clr", alarme, 1'b0);
`endif
        tick(3);

        // Fill never reaches high: timeout alarm.
        mid = 1'b0;
        high = 1'b0;
        tick(20);
        check("to_not_yet", alarme, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (alarme) found = 1'b1;
        end
        check("to_alarm_seen", found, 1'b1);
        tick(1);
        check("to_supply_closed", watter_supply, 1'b0);
        tick(10);
        check("to_supply_stays", watter_supply, 1'b0);
        check("to_alarm_stays", alarme, 1'b1);
`ifdef ALARM_LATCH_EN
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        check("to_alarm_cleared", alarme, 1'b0);
        tick(1);
        check("to_supply_reopen", watter_supply, 1'b1);
`endif
        mid = 1'b1;
        high = 1'b1;
        tick(8);

        // Asynchronous reset in the middle of a drip run.
        us = 1'b1;
        t = 1'b1;
        tick(6);
        check("rst_drip_on", got, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_got", got, 1'b0);
        check("rst_async_asp", asp, 1'b0);
        check("rst_async_supply", watter_supply, 1'b0);
        check("rst_async_alarme", alarme, 1'b0);
        tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
